// File: rtl/text_scroll_ctrl_pkg.sv
// Shared constants for the text scroller: character codes, message ROMs,
// FSM states and segment helpers.
package text_scroll_ctrl_pkg;

  localparam int unsigned MSG_LEN   = 16;
  localparam int unsigned DIGITS    = 4;
  localparam int unsigned POS_BITS  = 4;
  localparam int unsigned CODE_BITS = 5;
  localparam int unsigned SEG_BITS  = 7;

  typedef logic [CODE_BITS-1:0] char_t;
  typedef logic [SEG_BITS-1:0]  seg_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_PAUSE
  } state_e;

  // Character codes; anything past CH_DASH has no glyph and shows blank.
  localparam char_t CH_BLANK = 5'd0;
  localparam char_t CH_0     = 5'd1;
  localparam char_t CH_1     = 5'd2;
  localparam char_t CH_2     = 5'd3;
  localparam char_t CH_3     = 5'd4;
  localparam char_t CH_4     = 5'd5;
  localparam char_t CH_5     = 5'd6;
  localparam char_t CH_6     = 5'd7;
  localparam char_t CH_7     = 5'd8;
  localparam char_t CH_8     = 5'd9;
  localparam char_t CH_9     = 5'd10;
  localparam char_t CH_A     = 5'd11;
  localparam char_t CH_B     = 5'd12;
  localparam char_t CH_C     = 5'd13;
  localparam char_t CH_D     = 5'd14;
  localparam char_t CH_E     = 5'd15;
  localparam char_t CH_F     = 5'd16;
  localparam char_t CH_H     = 5'd17;
  localparam char_t CH_L     = 5'd18;
  localparam char_t CH_N     = 5'd19;
  localparam char_t CH_O     = 5'd20;
  localparam char_t CH_P     = 5'd21;
  localparam char_t CH_R     = 5'd22;
  localparam char_t CH_S     = 5'd23;
  localparam char_t CH_T     = 5'd24;
  localparam char_t CH_U     = 5'd25;
  localparam char_t CH_Y     = 5'd26;
  localparam char_t CH_DASH  = 5'd27;
  localparam char_t CH_UNK   = 5'd31;

  localparam seg_t SEG_BLANK = 7'h7F;

  // "HELLO UP 0123456"
  localparam char_t MSG_A [0:MSG_LEN-1] = '{
    CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK, CH_U, CH_P,
    CH_BLANK, CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6
  };

  // "SCORE 789 ADP?-F" ('?' is an unassigned code)
  localparam char_t MSG_B [0:MSG_LEN-1] = '{
    CH_S, CH_C, CH_O, CH_R, CH_E, CH_BLANK, CH_7, CH_8,
    CH_9, CH_BLANK, CH_A, CH_D, CH_P, CH_UNK, CH_DASH, CH_F
  };

  function automatic char_t msg_char(input logic sel, input logic [POS_BITS-1:0] idx);
    return sel ? MSG_B[idx] : MSG_A[idx];
  endfunction

endpackage

// File: rtl/text_scroll_ctrl_if.sv
// Select/enable inputs and display outputs of the text scroller.
interface text_scroll_ctrl_if;
  import text_scroll_ctrl_pkg::*;

  logic                         sel_clean_i;
  logic                         scroll_en_i;
  logic [DIGITS*SEG_BITS-1:0]   win_seg_o;
  logic                         msg_id_o;
  logic [POS_BITS-1:0]          pos_o;
  logic                         wrap_o;

  modport master (
    output sel_clean_i, scroll_en_i,
    input  win_seg_o, msg_id_o, pos_o, wrap_o
  );

  modport slave (
    input  sel_clean_i, scroll_en_i,
    output win_seg_o, msg_id_o, pos_o, wrap_o
  );
endinterface

// File: rtl/char_seg_decoder.sv
// Character code to active-low 7-segment pattern {g..a}; unknown codes blank.
module char_seg_decoder
  import text_scroll_ctrl_pkg::*;
(
  input  char_t code_i,
  output seg_t  seg_o
);

  // Glyph lookup
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (code_i)
      CH_BLANK: seg_o = SEG_BLANK;
      CH_0:     seg_o = 7'h40;
      CH_1:     seg_o = 7'h79;
      CH_2:     seg_o = 7'h24;
      CH_3:     seg_o = 7'h30;
      CH_4:     seg_o = 7'h19;
      CH_5:     seg_o = 7'h12;
      CH_6:     seg_o = 7'h02;
      CH_7:     seg_o = 7'h78;
      CH_8:     seg_o = 7'h00;
      CH_9:     seg_o = 7'h10;
      CH_A:     seg_o = 7'h08;
      CH_B:     seg_o = 7'h03;
      CH_C:     seg_o = 7'h46;
      CH_D:     seg_o = 7'h21;
      CH_E:     seg_o = 7'h06;
      CH_F:     seg_o = 7'h0E;
      CH_H:     seg_o = 7'h09;
      CH_L:     seg_o = 7'h47;
      CH_N:     seg_o = 7'h2B;
      CH_O:     seg_o = 7'h40;
      CH_P:     seg_o = 7'h0C;
      CH_R:     seg_o = 7'h2F;
      CH_S:     seg_o = 7'h12;
      CH_T:     seg_o = 7'h07;
      CH_U:     seg_o = 7'h41;
      CH_Y:     seg_o = 7'h11;
      CH_DASH:  seg_o = 7'h3F;
      default:  seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/text_scroll_ctrl.sv
// Scrolls a 4-character window across one of two fixed messages and drives
// registered 7-segment patterns for the display multiplexer.
module text_scroll_ctrl
  import text_scroll_ctrl_pkg::*;
#(
  parameter int unsigned SCROLL_LIMIT = 25_000_000,
  parameter int unsigned CNT_BITS     = 25
) (
  input logic              clk,
  input logic              rst,
  text_scroll_ctrl_if.slave bus
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(SCROLL_LIMIT - 1);

  state_e                     state_q;
  logic                       sel_q;
  logic                       msg_id_q;
  logic [POS_BITS-1:0]        pos_q;
  logic [CNT_BITS-1:0]        cnt_q;
  logic                       wrap_q;
  logic [DIGITS*SEG_BITS-1:0] win_seg_q;
  logic [DIGITS*SEG_BITS-1:0] win_seg_d;

  logic sel_chg;
  logic step_tick;

  assign sel_chg   = bus.sel_clean_i ^ sel_q;
  assign step_tick = (cnt_q == CNT_LAST);

  // Digit k (0 = rightmost) shows character pos+DIGITS-1-k, wrapping mod MSG_LEN.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [POS_BITS-1:0] idx;
    char_t               code;

    assign idx  = pos_q + POS_BITS'(DIGITS - 1 - k);
    assign code = msg_char(msg_id_q, idx);

    char_seg_decoder u_dec (
      .code_i (code),
      .seg_o  (win_seg_d[k*SEG_BITS +: SEG_BITS])
    );
  end

  // Select input history for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= 1'b0;
    else     sel_q <= bus.sel_clean_i;
  end

  // Scroll FSM with step counter, position and wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      msg_id_q <= 1'b0;
      pos_q    <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          msg_id_q <= sel_q;
          pos_q    <= '0;
          cnt_q    <= '0;
          state_q  <= bus.scroll_en_i ? ST_RUN : ST_PAUSE;
        end
        ST_RUN: begin
          if (sel_chg) begin
            state_q <= ST_LOAD;
          end else if (!bus.scroll_en_i) begin
            state_q <= ST_PAUSE;
          end else if (step_tick) begin
            cnt_q  <= '0;
            pos_q  <= pos_q + 1'b1;
            wrap_q <= (pos_q == '1);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (sel_chg)               state_q <= ST_LOAD;
          else if (bus.scroll_en_i)  state_q <= ST_RUN;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Window pattern register, one cycle behind pos/msg_id
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_seg_q <= '1;
    else     win_seg_q <= win_seg_d;
  end

  assign bus.win_seg_o = win_seg_q;
  assign bus.msg_id_o  = msg_id_q;
  assign bus.pos_o     = pos_q;
  assign bus.wrap_o    = wrap_q;

endmodule

// File: tb/tb_text_scroll_ctrl.sv
// Self-checking bench for text_scroll_ctrl: directed scenarios with literal
// expectations plus randomized select/enable/reset against a behavioural model.
module tb_text_scroll_ctrl;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  text_scroll_ctrl_if bus_if ();

  text_scroll_ctrl #(.SCROLL_LIMIT(LIMIT), .CNT_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  string msg_a = "HELLO UP 0123456";
  string msg_b = "SCORE 789 ADP?-F";

  // Behavioural model state
  bit          m_loading = 1'b1;
  bit          m_running = 1'b0;
  int          m_ticks   = 0;
  int          m_pos     = 0;
  int          m_msg     = 0;
  bit          m_sel_prev = 1'b0;
  bit          m_wrap    = 1'b0;
  logic [27:0] m_win     = 28'hFFFFFFF;

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0": return 7'h40;  "1": return 7'h79;  "2": return 7'h24;
      "3": return 7'h30;  "4": return 7'h19;  "5": return 7'h12;
      "6": return 7'h02;  "7": return 7'h78;  "8": return 7'h00;
      "9": return 7'h10;  "A": return 7'h08;  "B": return 7'h03;
      "C": return 7'h46;  "D": return 7'h21;  "E": return 7'h06;
      "F": return 7'h0E;  "H": return 7'h09;  "L": return 7'h47;
      "N": return 7'h2B;  "O": return 7'h40;  "P": return 7'h0C;
      "R": return 7'h2F;  "S": return 7'h12;  "T": return 7'h07;
      "U": return 7'h41;  "Y": return 7'h11;  "-": return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] window_of(input int p, input int m);
    logic [27:0] w;
    string s;
    s = (m != 0) ? msg_b : msg_a;
    w = '1;
    for (int k = 0; k < 4; k++) w[7*k +: 7] = seg_of(s[(p + 3 - k) % 16]);
    return w;
  endfunction

  // Reference model: advance on each clock, clear on reset
  always @(posedge clk or posedge rst) begin
    int  old_pos;
    int  old_msg;
    bit  chg;
    bit  en;
    if (rst) begin
      m_loading = 1'b1; m_running = 1'b0; m_ticks = 0; m_pos = 0; m_msg = 0;
      m_sel_prev = 1'b0; m_wrap = 1'b0; m_win = 28'hFFFFFFF;
    end else begin
      old_pos = m_pos;
      old_msg = m_msg;
      en      = bus_if.scroll_en_i;
      chg     = bus_if.sel_clean_i ^ m_sel_prev;
      m_wrap  = 1'b0;
      if (m_loading) begin
        m_msg = int'(m_sel_prev); m_pos = 0; m_ticks = 0;
        m_loading = 1'b0; m_running = en;
      end else if (chg) begin
        m_loading = 1'b1;
      end else if (m_running) begin
        if (!en) m_running = 1'b0;
        else if (m_ticks == LIMIT - 1) begin
          m_ticks = 0;
          m_wrap  = (m_pos == 15);
          m_pos   = (m_pos + 1) % 16;
        end else m_ticks++;
      end else if (en) begin
        m_running = 1'b1;
      end
      m_sel_prev = bus_if.sel_clean_i;
      m_win      = window_of(old_pos, old_msg);
    end
  end

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("win_seg", bus_if.win_seg_o, m_win);
    check("msg_id",  28'(bus_if.msg_id_o), 28'(m_msg));
    check("pos",     28'(bus_if.pos_o), 28'(m_pos));
    check("wrap",    28'(bus_if.wrap_o), 28'(m_wrap));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int wraps;
    bus_if.sel_clean_i = 1'b0;
    bus_if.scroll_en_i = 1'b1;
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;

    // 1: first window after reset release
    step(2);
    check("t1_pos", 28'(bus_if.pos_o), 28'd0);
    check("t1_msg", 28'(bus_if.msg_id_o), 28'd0);
    check("t1_win", bus_if.win_seg_o, {7'h09, 7'h06, 7'h47, 7'h47});

    // 2: 16 steps, single wrap pulse
    wraps = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (bus_if.wrap_o) wraps++;
    end
    check("t2_wraps", 28'(wraps), 28'd1);
    check("t2_pos", 28'(bus_if.pos_o), 28'd0);

    // 3: pause at pos 5 mid-count, resume with remaining count
    for (int i = 0; i < 200 && !(m_pos == 5 && m_ticks == 1 && m_running); i++) step(1);
    check("t3_wait", 28'(m_pos == 5 && m_ticks == 1 && m_running), 28'd1);
    bus_if.scroll_en_i = 1'b0;
    step(20);
    check("t3_hold", 28'(bus_if.pos_o), 28'd5);
    bus_if.scroll_en_i = 1'b1;
    step(3);
    check("t3_early", 28'(bus_if.pos_o), 28'd5);
    step(1);
    check("t3_adv", 28'(bus_if.pos_o), 28'd6);

    // 4: switch to message B at pos 9
    for (int i = 0; i < 200 && !(m_pos == 9 && m_running); i++) step(1);
    check("t4_wait", 28'(m_pos == 9 && m_running), 28'd1);
    bus_if.sel_clean_i = 1'b1;
    step(3);
    check("t4_msg", 28'(bus_if.msg_id_o), 28'd1);
    check("t4_pos", 28'(bus_if.pos_o), 28'd0);
    check("t4_win", bus_if.win_seg_o, {7'h12, 7'h46, 7'h40, 7'h2F});
    step(2);
    check("t4_pos_hold", 28'(bus_if.pos_o), 28'd0);
    step(1);
    check("t4_pos_step", 28'(bus_if.pos_o), 28'd1);

    // 5: select change on the step tick at pos 15
    for (int i = 0; i < 200 && !(m_pos == 15 && m_ticks == LIMIT - 1 && m_running && !m_loading); i++) step(1);
    check("t5_wait", 28'(m_pos == 15 && m_ticks == LIMIT - 1 && m_running), 28'd1);
    bus_if.sel_clean_i = 1'b0;
    step(1);
    check("t5_pos_noadv", 28'(bus_if.pos_o), 28'd15);
    check("t5_nowrap", 28'(bus_if.wrap_o), 28'd0);
    step(1);
    check("t5_pos0", 28'(bus_if.pos_o), 28'd0);
    check("t5_msg", 28'(bus_if.msg_id_o), 28'd0);

    // 6: async reset mid-scroll on B, then wrap-around window on A
    bus_if.sel_clean_i = 1'b1;
    for (int i = 0; i < 200 && !(m_pos == 12 && m_msg == 1); i++) step(1);
    check("t6_wait", 28'(m_pos == 12 && m_msg == 1), 28'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_win", bus_if.win_seg_o, 28'hFFFFFFF);
    check("t6_rst_pos", 28'(bus_if.pos_o), 28'd0);
    check("t6_rst_msg", 28'(bus_if.msg_id_o), 28'd0);
    bus_if.sel_clean_i = 1'b0;
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 200 && !(m_pos == 14 && m_msg == 0); i++) step(1);
    check("t6_wait14", 28'(m_pos == 14 && m_msg == 0), 28'd1);
    step(1);
    check("t6_win14", bus_if.win_seg_o, {7'h12, 7'h02, 7'h09, 7'h06});

    // Randomized select / enable / reset traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) bus_if.scroll_en_i = ($urandom_range(0, 3) != 0);
      if (r >= 96) bus_if.sel_clean_i = ~bus_if.sel_clean_i;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
